lcd_12864b_text_feeder: RTL
===========================

Name: lcd_12864b_text_feeder

Overview:
- Upstream producer for lcd_12864b. Holds a 4-row x 16-column character shadow buffer written by host logic.
- Runs the display init sequence once after reset, then streams dirty rows into the lcd_12864b write queue: one cursor-position instruction, then 16 data bytes per row.
- Replaces hand-sequenced feeding at top level; lcd_12864b's queue flags are the only flow control.

Parameters:
QS, 8, lcd_12864b queue depth; must equal the lcd_12864b QS; power of 2, >=4.
CLR_WAIT, 300000, clk cycles waited after a clear-display (0x01) push before any further push.

Ports:
clk  in  1  system clock, same clock as lcd_12864b.
rst_n  in  1  reset, asynchronous, active-low.
wr_en  in  1  host character write strobe, one cycle per write.
wr_row  in  2  target row 0..3.
wr_col  in  4  target column 0..15.
wr_char  in  8  character code.
clr  in  1  clear-screen request pulse.
busy  out  1  high while init, clear or any row transfer is pending or running.
q_data  out  8  byte to lcd_12864b in_data.
q_cmd  out  1  to lcd_12864b cmd; 0=instruction, 1=display data.
q_wp  out  $clog2(QS)  queue write pointer, to lcd_12864b pWR.
q_full  in  1  from lcd_12864b full.
q_empty  in  1  high when lcd_12864b queue is empty and its last byte has completed on the bus.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: q_data=0, q_cmd=0, q_wp=0, busy=1. All 64 shadow bytes = 0x20. Dirty[3:0]=0, clr_pend=0, state=INIT_A.
- Push rule: at most one push per cycle, and only when q_full=0 in that cycle.
  - On a push edge, q_data takes the byte and q_wp increments modulo QS in the same edge.
  - No push -> q_wp holds.
- Cmd rule: q_cmd changes only in a cycle with q_empty=1 and no push. Every state that needs a different q_cmd first waits for q_empty, switches q_cmd, then starts pushing.
- Host write: on wr_en, shadow[row][col] <= wr_char and dirty[row] <= 1 at that edge, in every state (including INIT and CLR).
- Clear request: clr sets clr_pend. It is taken only in IDLE, so an in-flight row always completes.
- States:
  - INIT_A: q_cmd=0; push 0x30, then 0x0C, then 0x01 -> CLR_DLY(next=INIT_B).
  - INIT_B: push 0x06 -> IDLE.
  - IDLE: priority is clr_pend first, then the lowest-index dirty row.
    - clr_pend=1 -> shadow all 0x20, dirty=0, clr_pend=0 -> CMD_SW(0) -> CLR_PUSH.
    - Else any dirty -> r = lowest dirty index; dirty[r] <= 0 -> CMD_SW(0) -> POS.
    - Else busy=0.
  - CLR_PUSH: push 0x01 -> CLR_DLY(next=IDLE).
  - CLR_DLY: wait q_empty, then count CLR_WAIT cycles -> next.
  - POS: push pos[r]; row0=0x80, row1=0x90, row2=0x88, row3=0x98 -> CMD_SW(1) -> DATA.
  - DATA: push shadow[r][c] for c=0..15; each byte is read in the cycle it is pushed -> IDLE after c=15.
  - CMD_SW(v): wait q_empty=1, set q_cmd=v, next cycle continue.
- Boundaries:
  - Write to row r while r is streaming re-sets dirty[r]. Columns not yet pushed show the new value; the row is resent later.
  - wr_en and a clear acceptance in the same edge: the write wins for that byte and dirty[row]=1 after the clear.
  - q_full high indefinitely: stall in place; no state, data or pointer change.
  - q_wp wraps QS-1 -> 0.
  - rst_n low mid-stream: immediate return to reset values; init reruns after release.
- busy = (state != IDLE) | (|dirty) | clr_pend.

Test Plan:
- Reset release, q_full=0, q_empty model = real lcd_12864b -> pushes 0x30, 0x0C, 0x01 with q_cmd=0. Then no push for >=CLR_WAIT cycles, then 0x06; q_wp=4; busy falls.
- Write 'A' (0x41) at row2 col0 -> q_cmd=0 push 0x88, q_cmd switches to 1 only after q_empty, then 0x41 followed by fifteen 0x20; q_wp advances by 17.
- Writes to rows 3 and 1 in the same idle period -> row1 (0x90 + 16 bytes) is sent before row3 (0x98 + 16 bytes).
- Hold q_full=1 for 50 cycles mid-DATA -> q_wp and q_data frozen; resumes with the next column byte, no loss or duplicate.
- clr during a row-0 transfer -> row 0 completes, then 0x01 with q_cmd=0, CLR_WAIT idle gap; shadow reads 0x20; no dirty rows.
- Write to row1 col15 while row1 col3 is being pushed -> the new char appears in this pass and row1 is resent once more. Assert rst_n low mid-DATA -> all outputs at reset values immediately.

Source files
------------

// File: rtl/lcd_12864b_text_feeder.sv
// ============================================================================
// lcd_12864b_text_feeder
// Streams a 4x16 character shadow buffer into the lcd_12864b write queue.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lcd_12864b_text_feeder #(
    parameter int QS       = 8,
    parameter int CLR_WAIT = 300000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [1:0]            wr_row,
    input  logic [3:0]            wr_col,
    input  logic [7:0]            wr_char,
    input  logic                  clr,
    output logic                  busy,
    output logic [7:0]            q_data,
    output logic                  q_cmd,
    output logic [$clog2(QS)-1:0] q_wp,
    input  logic                  q_full,
    input  logic                  q_empty
);

    localparam int AW = $clog2(QS);
    localparam int CW = $clog2(CLR_WAIT + 1);
    localparam logic [CW-1:0] C_DLY_LAST = CW'(CLR_WAIT - 1);

    typedef enum logic [2:0] {
        S_INIT_A   = 3'd0,
        S_INIT_B   = 3'd1,
        S_IDLE     = 3'd2,
        S_CMD_SW   = 3'd3,
        S_CLR_PUSH = 3'd4,
        S_CLR_DLY  = 3'd5,
        S_POS      = 3'd6,
        S_DATA     = 3'd7
    } state_t;

    state_t        state, state_n, ret, ret_n;
    logic          cmdv, cmdv_n;
    logic [3:0]    idx, idx_n;
    logic [1:0]    row, row_n, low_row;
    logic [3:0]    dirty, dirty_nxt;
    logic          clr_pend;
    logic [7:0]    shadow [4][16];
    logic [CW-1:0] cnt;
    logic          dly_run;

    logic          push, set_cmd, take_row, clr_take;
    logic          dly_start, dly_done, dly_inc;
    logic [7:0]    push_byte, pos_byte;

    always_comb begin
        if (dirty[0])      low_row = 2'd0;
        else if (dirty[1]) low_row = 2'd1;
        else if (dirty[2]) low_row = 2'd2;
        else               low_row = 2'd3;
    end

    always_comb begin
        case (row)
            2'd0:    pos_byte = 8'h80;
            2'd1:    pos_byte = 8'h90;
            2'd2:    pos_byte = 8'h88;
            default: pos_byte = 8'h98;
        endcase
    end

    always_comb begin
        state_n   = state;
        ret_n     = ret;
        cmdv_n    = cmdv;
        idx_n     = idx;
        row_n     = row;
        push      = 1'b0;
        push_byte = 8'h00;
        set_cmd   = 1'b0;
        take_row  = 1'b0;
        clr_take  = 1'b0;
        dly_start = 1'b0;
        dly_done  = 1'b0;
        dly_inc   = 1'b0;
        case (state)
            S_INIT_A: begin
                push_byte = (idx == 4'd0) ? 8'h30 : (idx == 4'd1) ? 8'h0C : 8'h01;
                if (!q_full) begin
                    push = 1'b1;
                    if (idx == 4'd2) begin
                        idx_n   = 4'd0;
                        ret_n   = S_INIT_B;
                        state_n = S_CLR_DLY;
                    end else begin
                        idx_n = idx + 4'd1;
                    end
                end
            end
            S_INIT_B: begin
                push_byte = 8'h06;
                if (!q_full) begin
                    push    = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_IDLE: begin
                if (clr_pend) begin
                    clr_take = 1'b1;
                    cmdv_n   = 1'b0;
                    ret_n    = S_CLR_PUSH;
                    state_n  = S_CMD_SW;
                end else if (|dirty) begin
                    take_row = 1'b1;
                    row_n    = low_row;
                    cmdv_n   = 1'b0;
                    ret_n    = S_POS;
                    state_n  = S_CMD_SW;
                end
            end
            // q_cmd only flips once the previous byte has fully left the bus
            S_CMD_SW: begin
                if (q_empty) begin
                    set_cmd = 1'b1;
                    state_n = ret;
                end
            end
            S_CLR_PUSH: begin
                push_byte = 8'h01;
                if (!q_full) begin
                    push    = 1'b1;
                    ret_n   = S_IDLE;
                    state_n = S_CLR_DLY;
                end
            end
            S_CLR_DLY: begin
                if (!dly_run) begin
                    dly_start = q_empty;
                end else if (cnt == C_DLY_LAST) begin
                    dly_done = 1'b1;
                    state_n  = ret;
                end else begin
                    dly_inc = 1'b1;
                end
            end
            S_POS: begin
                push_byte = pos_byte;
                if (!q_full) begin
                    push    = 1'b1;
                    cmdv_n  = 1'b1;
                    idx_n   = 4'd0;
                    ret_n   = S_DATA;
                    state_n = S_CMD_SW;
                end
            end
            default: begin
                push_byte = shadow[row][idx];
                if (!q_full) begin
                    push  = 1'b1;
                    idx_n = idx + 4'd1;
                    if (idx == 4'd15) state_n = S_IDLE;
                end
            end
        endcase
    end

    // A host write on the same edge as a clear or row pickup must survive it
    always_comb begin
        dirty_nxt = dirty;
        if (clr_take)      dirty_nxt = 4'd0;
        else if (take_row) dirty_nxt[low_row] = 1'b0;
        if (wr_en)         dirty_nxt[wr_row] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT_A;
            ret   <= S_IDLE;
            cmdv  <= 1'b0;
            idx   <= 4'd0;
            row   <= 2'd0;
        end else begin
            state <= state_n;
            ret   <= ret_n;
            cmdv  <= cmdv_n;
            idx   <= idx_n;
            row   <= row_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_data   <= 8'h00;
            q_cmd    <= 1'b0;
            q_wp     <= '0;
            dirty    <= 4'd0;
            clr_pend <= 1'b0;
            cnt      <= '0;
            dly_run  <= 1'b0;
        end else begin
            if (push) begin
                q_data <= push_byte;
                q_wp   <= q_wp + AW'(1);
            end
            if (set_cmd) q_cmd <= cmdv;
            dirty <= dirty_nxt;
            if (clr)           clr_pend <= 1'b1;
            else if (clr_take) clr_pend <= 1'b0;
            if (dly_start) begin
                dly_run <= 1'b1;
                cnt     <= '0;
            end else if (dly_done) begin
                dly_run <= 1'b0;
            end else if (dly_inc) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 16; c++)
                    shadow[r][c] <= 8'h20;
        end else begin
            if (clr_take)
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 16; c++)
                        shadow[r][c] <= 8'h20;
            if (wr_en) shadow[wr_row][wr_col] <= wr_char;
        end
    end

    assign busy = (state != S_IDLE) | (|dirty) | clr_pend;

endmodule

`default_nettype wire
